// File: rtl/riscv_dmem.sv
// riscv_dmem: data-port memory subsystem. Word RAM with registered read, plus an MMIO
// window holding a buffered 8N1 UART transmitter and a free-running cycle counter.
//
// state   | meaning
// S_IDLE  | line idle (tx=1), waiting for a queued byte
// S_START | start bit (tx=0) for BAUD_DIV cycles
// S_DATA  | 8 data bits LSB first, BAUD_DIV cycles each
// S_STOP  | stop bit (tx=1); chains straight into the next frame if bytes are queued
module riscv_dmem #(
  parameter int MEM_DEPTH  = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o
);

  localparam int AW  = $clog2(MEM_DEPTH);
  localparam int FPW = $clog2(FIFO_DEPTH);
  localparam int CW  = FPW + 1;
  localparam int BW  = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST     = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          is_mmio;
  logic [1:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          rd_en;
  logic          wr_en;
  logic          tx_push;
  logic          ovf_clr;
  logic          unused_addr;

  assign is_mmio     = data_addr_i[31];
  assign reg_sel     = data_addr_i[3:2];
  assign ram_idx     = data_addr_i[AW+1:2];
  assign rd_en       = data_ce_i && !data_we_i;
  assign wr_en       = data_ce_i && data_we_i;
  assign tx_push     = wr_en && is_mmio && (reg_sel == 2'd0);
  assign ovf_clr     = wr_en && is_mmio && (reg_sel == 2'd1) && data_i[3];
  assign unused_addr = ^{data_addr_i[30:AW+2], data_addr_i[1:0]};

  // RAM: no reset on contents, synchronous read port
  logic [31:0] ram_mem [MEM_DEPTH];
  logic [31:0] ram_rdata_q;

  always_ff @(posedge clk) begin
    if (wr_en && !is_mmio) ram_mem[ram_idx] <= data_i;
    if (rd_en && !is_mmio) ram_rdata_q <= ram_mem[ram_idx];
  end

  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [FPW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FPW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           fifo_empty;
  logic           fifo_full;
  logic           fifo_pop;
  logic           push_ok;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FIFO_FULL_CNT);
  assign push_ok    = tx_push && (!fifo_full || fifo_pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= data_i[7:0];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (fifo_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, fifo_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (tx_push && !push_ok) ovf_d = 1'b1;
    else if (ovf_clr)        ovf_d = 1'b0;
  end

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_done;

  assign baud_done = (baud_q == '0);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_mem[rd_ptr_q];
          baud_d   = BAUD_LAST;
          state_d  = S_START;
          tx_d     = 1'b0;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = BAUD_LAST;
          bit_d   = 3'd7;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = BAUD_LAST;
          if (bit_q == 3'd0) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q - 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_mem[rd_ptr_q];
            baud_d   = BAUD_LAST;
            tx_d     = 1'b0;
            state_d  = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  logic [31:0] count_q, count_d;
  logic [31:0] status;
  logic [31:0] mmio_val;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic        rd_mmio_q, rd_mmio_d;

  assign count_d = count_q + 32'd1;
  assign status  = {23'd0, 5'(cnt_q), ovf_q, fifo_empty, fifo_full, (state_q != S_IDLE)};

  always_comb begin
    mmio_val = 32'd0;
    case (reg_sel)
      2'd1:    mmio_val = status;
      2'd2:    mmio_val = count_q;
      default: mmio_val = 32'd0;
    endcase
  end

  // data_o selects between the RAM read register and the MMIO read register
  always_comb begin
    rd_mmio_d    = rd_mmio_q;
    mmio_rdata_d = mmio_rdata_q;
    if (rd_en) begin
      rd_mmio_d = is_mmio;
      if (is_mmio) mmio_rdata_d = mmio_val;
    end
  end

  assign data_o = rd_mmio_q ? mmio_rdata_q : ram_rdata_q;
  assign tx_o   = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      count_q      <= '0;
      rd_mmio_q    <= 1'b1;
      mmio_rdata_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      count_q      <= count_d;
      rd_mmio_q    <= rd_mmio_d;
      mmio_rdata_q <= mmio_rdata_d;
    end
  end

endmodule

// File: tb/tb_riscv_dmem.sv
// Scoreboarded bench for riscv_dmem: reads push expectations, a monitor pops them one
// cycle later; a bench-side UART receiver decodes tx_o frames against expected bytes.
module tb_riscv_dmem;
  localparam int MEM_DEPTH  = 1024;
  localparam int FIFO_DEPTH = 4;
  localparam int BAUD_DIV   = 4;
  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_CNT = 32'h8000_0008;
  localparam logic [31:0] A_RSV = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] data_o;
  logic        tx_o;

  riscv_dmem #(.MEM_DEPTH(MEM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .BAUD_DIV(BAUD_DIV)) dut (
    .clk(clk), .rst(rst), .data_ce_i(ce), .data_we_i(we), .data_addr_i(addr),
    .data_i(wdata), .data_o(data_o), .tx_o(tx_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // scoreboard
  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic        rd_pend;
  logic [31:0] m_cnt;
  int          cyc = 0;

  always @(posedge clk) begin
    rd_pend <= ce && !we && !rst;
    m_cnt   <= rst ? 32'd0 : m_cnt + 32'd1;
    cyc     <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rd_pend === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_read: got %08h expected none", data_o);
      end else begin
        check(nm_q.pop_front(), data_o, exp_q.pop_front());
      end
    end
  end

  // UART receiver model
  logic [7:0] rx_exp[$];
  int         rx_count = 0;
  logic       rx_en = 1'b1;
  logic       b2b_chk = 1'b0;
  int         last_start = 0;

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rx_en && !rst && tx_o === 1'b0) begin
        if (b2b_chk && rx_count >= 2) check("b2b_gap", 32'(cyc - last_start), 32'(10 * BAUD_DIV));
        last_start = cyc;
        b = '0;
        repeat (BAUD_DIV + BAUD_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = tx_o;
          repeat (BAUD_DIV) @(negedge clk);
        end
        check("stop_bit", 32'(tx_o), 32'd1);
        if (rx_exp.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rx_unexpected_frame: got %02h expected none", b);
        end else begin
          check("rx_byte", 32'(b), 32'(rx_exp.pop_front()));
        end
        rx_count++;
      end
    end
  end

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(e);
    nm_q.push_back(n);
    @(posedge clk);
    #1 ce = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 begin ce = 1'b0; we = 1'b0; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ce = 1'b0; we = 1'b0;
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k = 0;
    while (rx_count < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frames_done", 32'(rx_count), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] first;
    logic        exp_tx;
    int          lows;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_o", data_o, 32'd0);
    check("rst_tx", 32'(tx_o), 32'd1);
    rst = 1'b0;
    rd(A_ST, 32'h4, "status_after_rst");
    rd(A_RSV, 32'h0, "reserved_read");

    // RAM, aliasing and hold
    wr(32'h10, 32'h1234_5678);
    wr(A_RSV, 32'hFFFF_FFFF);
    rd(32'h12, 32'h1234_5678, "ram_read");
    rd(32'h10 + 4 * MEM_DEPTH, 32'h1234_5678, "ram_alias_depth");
    rd(32'h7FFF_F010, 32'h1234_5678, "ram_alias_high");
    wr(32'h20, 32'hDEAD_BEEF);
    idle(1);
    check("hold_after_write", data_o, 32'h1234_5678);
    rd(32'h20, 32'hDEAD_BEEF, "ram_read2");
    rd(A_TX, 32'h0, "txdata_read");
    rd(A_ST, 32'h4, "status_after_txread");

    // single frame, exact waveform
    rx_exp.push_back(8'h55);
    wr(A_TX, 32'h55);
    @(negedge clk);
    check("tx_before_start", 32'(tx_o), 32'd1);
    for (int k = 0; k < 39; k++) begin
      @(negedge clk);
      if (k < 4) exp_tx = 1'b0;
      else if (k < 36) exp_tx = (8'h55 >> ((k - 4) / 4)) & 1'b1;
      else exp_tx = 1'b1;
      check("tx_wave", 32'(tx_o), 32'(exp_tx));
    end
    rd(A_ST, 32'h5, "busy_last_stop_cycle");
    rd(A_ST, 32'h4, "idle_after_frame");
    wait_frames(1, 20);

    // FIFO fill and overflow
    b2b_chk = 1'b1;
    rx_exp.push_back(8'h11);
    rx_exp.push_back(8'h22);
    rx_exp.push_back(8'h33);
    rx_exp.push_back(8'h44);
    rx_exp.push_back(8'h5A);
    wr(A_TX, 32'h11);
    wr(A_TX, 32'h22);
    wr(A_TX, 32'h33);
    wr(A_TX, 32'h44);
    wr(A_TX, 32'h5A);
    wr(A_TX, 32'h66);
    rd(A_ST, 32'h4B, "status_full_ovf");
    wait_frames(6, 5 * 10 * BAUD_DIV + 50);
    b2b_chk = 1'b0;
    idle(4);
    rd(A_ST, 32'hC, "status_ovf_sticky");
    wr(A_ST, 32'h7);
    rd(A_ST, 32'hC, "status_ovf_kept");
    wr(A_ST, 32'h8);
    rd(A_ST, 32'h4, "status_ovf_cleared");

    // cycle counter
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = A_CNT;
    first = m_cnt;
    exp_q.push_back(first);
    nm_q.push_back("count_first");
    @(posedge clk);
    #1 ce = 1'b0;
    idle(9);
    rd(A_CNT, first + 32'd10, "count_plus10");
    wr(A_CNT, 32'h0);
    @(negedge clk);
    force dut.count_q = 32'hFFFF_FFFF;
    #1 check("count_wrap_next", dut.count_d, 32'h0);
    ce = 1'b1; we = 1'b0; addr = A_CNT;
    exp_q.push_back(32'hFFFF_FFFF);
    nm_q.push_back("count_forced");
    @(posedge clk);
    #1 ce = 1'b0;
    @(negedge clk);
    release dut.count_q;

    // reset mid-frame with bytes queued
    rx_en = 1'b0;
    idle(2);
    wr(A_TX, 32'hA5);
    wr(A_TX, 32'h3C);
    wr(A_TX, 32'h0F);
    rd(A_ST, 32'h21, "status_two_queued");
    idle(10);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_tx", 32'(tx_o), 32'd1);
    check("rst_mid_data_o", data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(A_ST, 32'h4, "status_after_abort");
    lows = 0;
    repeat (12 * BAUD_DIV) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
    end
    check("no_frames_after_rst", 32'(lows), 32'd0);
    rd(A_ST, 32'h4, "status_final");

    idle(3);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("rx_drained", 32'(rx_exp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
